// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared status encodings and time-field widths for the
//                stopwatch control FSM and timekeeping datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // Control FSM status word; the reserved code is decoded as idle downstream
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_PAUSED   = 2'b10,
    ST_RESERVED = 2'b11
  } status_e;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 7;
  localparam int SEC_MAX = 59;

endpackage
`default_nettype wire

// File: rtl/stopwatch_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk down to a one-cycle tick every TICKS_PER_SEC
//                running cycles. Holds its count while not running so a
//                partial second survives a pause; clear discards it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W  = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == C_LAST);

  // Tick only fires when the edge that completes the second is a running edge
  assign tick = run && w_at_last;

  // Prescaler count: clear wins over run, otherwise hold when not running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_timer
//  Description : Timekeeping datapath. Decodes the control FSM status,
//                counts minutes:seconds on prescaler ticks, and emits
//                one-cycle second and wrap-around pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_MIN       = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       status,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic             sec_pulse,
  output logic             wrap
);

  localparam logic [SEC_W-1:0] C_SEC_LAST = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] C_MIN_LAST = MIN_W'(MAX_MIN);

  logic w_run;
  logic w_paused;
  logic w_clear;
  logic w_tick;

  // Status decode: anything that is neither running nor paused is idle
  assign w_run    = (status == ST_RUNNING);
  assign w_paused = (status == ST_PAUSED);
  assign w_clear  = !(w_run || w_paused);

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Time counters and pulses, updated together so the pulse marks the new value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seconds   <= '0;
      minutes   <= '0;
      sec_pulse <= 1'b0;
      wrap      <= 1'b0;
    end else if (w_clear) begin
      seconds   <= '0;
      minutes   <= '0;
      sec_pulse <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      sec_pulse <= w_tick;
      wrap      <= 1'b0;
      if (w_tick) begin
        if (seconds == C_SEC_LAST) begin
          seconds <= '0;
          if (minutes == C_MIN_LAST) begin
            minutes <= '0;
            wrap    <= 1'b1;
          end else begin
            minutes <= minutes + MIN_W'(1);
          end
        end else begin
          seconds <= seconds + SEC_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_timer.md
# stopwatch_timer

Timekeeping datapath of the stopwatch, directly downstream of the control FSM. Consumes the FSM's 2-bit `status` and produces the elapsed minutes:seconds value. Counts while running, holds while paused, and clears while idle. Emits one-cycle pulses on every second boundary and on wrap-around, for the display and alarm logic.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second. Minimum 2; use 4 in simulation.
- `MAX_MIN`, default 99: highest minute value. Must be 1..127.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `status`  in  2  FSM state: 00 idle, 01 running, 10 paused. 11 is treated as idle.
- `seconds`  out  6  elapsed seconds, 0..59. Registered.
- `minutes`  out  7  elapsed minutes, 0..MAX_MIN. Registered.
- `sec_pulse`  out  1  high for exactly one cycle, on the cycle that seconds/minutes update.
- `wrap`  out  1  high for one cycle when the time rolls from MAX_MIN:59 to 00:00. Coincides with `sec_pulse`.

## Operation
- **Reset.** While `rst_n` is low at a clock edge:
  - `seconds`, `minutes`, `sec_pulse`, `wrap` = 0.
  - Prescaler count = 0.
  - Reset overrides `status`.
- **Prescaler.** `cnt` has width clog2(TICKS_PER_SEC).
  - Running: `cnt` increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and asserts the internal `tick`.
  - Paused: `cnt` holds its value, so a partial second is preserved across pause and resume.
  - Idle (or 11): `cnt` clears to 0.
- **Time counters.** Update only on `tick`, which only occurs when `status` = running.
  - `seconds` < 59: increment `seconds`.
  - `seconds` = 59: set `seconds` to 0 and increment `minutes`.
  - Time = MAX_MIN:59: set both to 0 and assert `wrap`.
- **Modes.**
  - Paused: `seconds` and `minutes` hold.
  - Idle (or 11): both clear to 0 at the next edge.
- **Pulses.** `sec_pulse` is registered alongside the counter update, so it is high in the same cycle the new value appears. Both pulses are 0 in any cycle without a tick.
- **Status changes mid-second.** Running→paused on the edge where `cnt` = TICKS_PER_SEC-1 does not tick, because `status` is sampled on the same edge. Running→idle clears everything, including any pending partial second.
- No saturation mode: the count always wraps.

## Timing
- First update comes exactly TICKS_PER_SEC running cycles after `status` first reads 01 from idle. Counted from the first edge that samples 01, `seconds` = 1 becomes visible after the TICKS_PER_SEC-th edge.
- Subsequent updates are spaced exactly TICKS_PER_SEC running cycles apart. Paused cycles are excluded.
- Outputs have 1-cycle latency from the `tick` condition. There is no combinational path from `status` to any output.
- Idle clear: outputs read 00:00 on the cycle after the first edge that samples idle.
- Reset mid-count: outputs read zero one edge after `rst_n` is sampled low. Counting resumes only after `rst_n` is high and `status` = running.

## Structure
- Shared package `stopwatch_pkg`. It holds:
  - Status encodings `ST_IDLE`, `ST_RUNNING`, `ST_PAUSED`. The control FSM must import the same constants.
  - Width constants `SEC_W` = 6 and `MIN_W` = 7.
  - `SEC_MAX` = 59.
- Sub-module `tick_prescaler`:
  - Parameter `TICKS_PER_SEC`.
  - Inputs: `clk`, `rst_n`, `run`, `clear`.
  - Output: one-cycle `tick`.
- Top level contains the status decode, the seconds/minutes counters and the pulse registers.

## Test plan
All scenarios use TICKS_PER_SEC = 4 and MAX_MIN = 2.
1. Reset, then hold running for 8 cycles → `seconds` steps 0→1→2, with `sec_pulse` high on exactly cycles 4 and 8. `minutes` = 0.
2. Run 6 cycles, pause 10 cycles, run again → `seconds` = 1 during the pause. Reaches 2 after 2 further running cycles, proving the partial second is preserved.
3. Run until 00:59, then one more tick → output reads 01:00 and `wrap` stays 0.
4. Run until 02:59, then one more tick → output reads 00:00, with `wrap` = `sec_pulse` = 1 for a single cycle.
5. Running at 01:30 with `cnt` = 2, drive idle for 1 cycle, then running → 00:00 the cycle after idle. Next tick comes 4 cycles after running resumes.
6. Running at 00:45, drop `rst_n` for 1 cycle with `status` = running → all outputs 0 on the next cycle. Count restarts and the first tick arrives 4 cycles after `rst_n` returns high. Driving `status` = 11 behaves like idle.
